// File: rtl/weight_bank.sv
// weight_bank: per-layer weight store of DEPTH rows x LANES signed lanes.
// Streams rows out for the forward pass, applies lane-wise signed deltas
// from backprop as a read-modify-write, and can zero the whole store.
module weight_bank #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 128,
    parameter int DEPTH    = 784,
    parameter int SATURATE = 0
) (
    input  logic                    clka,
    input  logic                    rst,
    input  logic                    start_rd,
    input  logic                    start_upd,
    input  logic                    start_clr,
    input  logic                    delta_valid,
    input  logic [LANES*DATA_W-1:0] delta,
    output logic [LANES*DATA_W-1:0] values,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err
);

    localparam int ROW_W = LANES * DATA_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, UPD, CLR} state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [ROW_W-1:0] mem [DEPTH];
    logic [ROW_W-1:0] sum_row_p0;
    logic             at_last;
    logic             any_start;
    logic             multi_start;

    // Lane add in DATA_W+1 bits; optionally clamp when the carry and sign disagree.
    function automatic logic signed [DATA_W-1:0] lane_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if ((SATURATE != 0) && (s[DATA_W] != s[DATA_W-1]))
            lane_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
        else
            lane_add = s[DATA_W-1:0];
    endfunction

    assign at_last     = (ptr == LAST);
    assign any_start   = start_rd | start_upd | start_clr;
    assign multi_start = (start_rd & start_upd) | (start_rd & start_clr) |
                         (start_upd & start_clr);

    // Stage p0: lane-wise sum of the addressed row and the incoming deltas.
    always_comb begin
        sum_row_p0 = '0;
        for (int j = 0; j < LANES; j++)
            sum_row_p0[j*DATA_W +: DATA_W] = lane_add(mem[ptr][j*DATA_W +: DATA_W],
                                                      delta[j*DATA_W +: DATA_W]);
    end

    // Sequencer: start arbitration, row pointer, registered outputs.
    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            values    <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            values    <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            case (state)
                IDLE: begin
                    start_err <= multi_start;
                    if (start_rd) begin
                        // Row 0 goes out on the accepting edge so back-to-back reads have no gap.
                        values   <= mem[0];
                        rd_valid <= 1'b1;
                        ptr      <= '0;
                        if (DEPTH == 1) begin
                            rd_last <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                            ptr   <= AW'(1);
                        end
                    end else if (start_upd) begin
                        state <= UPD;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end else if (start_clr) begin
                        state <= CLR;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                READ: begin
                    start_err <= any_start;
                    values    <= mem[ptr];
                    rd_valid  <= 1'b1;
                    if (at_last) begin
                        rd_last <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ptr     <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                UPD: begin
                    start_err <= any_start;
                    if (delta_valid) begin
                        if (at_last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                CLR: begin
                    start_err <= any_start;
                    if (at_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: row write-back; contents survive reset, and a reset edge never writes.
    always_ff @(posedge clka) begin
        if (!rst) begin
            if (state == UPD && delta_valid)
                mem[ptr] <= sum_row_p0;
            else if (state == CLR)
                mem[ptr] <= '0;
        end
    end

endmodule

// File: doc/weight_bank.md
Name: weight_bank

Overview:
Parametrised weight store for one network layer: DEPTH rows of LANES signed lanes, each DATA_W bits wide. It supports three sequenced operations. A streaming read emits one row per cycle. A streaming update applies per-lane signed deltas as a read-modify-write under a valid handshake. A clear zeroes every row. One instance is built per layer and sits between the forward-pass datapath, which consumes `values`, and the backprop datapath, which supplies `delta`.

Parameters:
- DATA_W, 32, bits per lane (signed two's complement)
- LANES, 128, lanes per row; ROW_W = LANES*DATA_W
- DEPTH, 784, rows; pointer width AW = $clog2(DEPTH), minimum 1
- SATURATE, 0, 1 = per-lane saturating add; 0 = wrapping add

Ports:
- clka  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_rd  in  1  request a full streaming read, sampled each edge
- start_upd  in  1  request a full streaming update
- start_clr  in  1  request a clear of all rows
- delta_valid  in  1  `delta` holds the next row's deltas (UPD state only)
- delta  in  ROW_W  per-lane deltas; lane j = [j*DATA_W +: DATA_W]
- values  out  ROW_W  registered read data
- rd_valid  out  1  `values` holds a valid row
- rd_last  out  1  `values` is row DEPTH-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when an operation completes
- start_err  out  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset: state IDLE, ptr 0. All outputs are 0: values, rd_valid, rd_last, busy, done, start_err. Memory contents are not reset and are retained across rst.
- Reset mid-operation aborts immediately to IDLE, with no done pulse. Rows already updated or cleared keep their new values; the remaining rows are untouched.
- States are IDLE, READ, UPD, CLR. busy is a registered copy of (state != IDLE).
- Start acceptance happens only in IDLE. Priority is rd > upd > clr.
  - The winning start moves to its state with ptr = 0.
  - Every other start asserted on that edge pulses start_err on the next cycle. This covers losers of simultaneous starts and any start sampled while busy.
  - A rejected start has no other effect.
- READ, with start_rd accepted at edge k:
  - After edge k+r, for r = 0..DEPTH-1: values = mem[r] and rd_valid = 1.
  - rd_last = 1 and done = 1 after edge k+DEPTH-1; the state returns to IDLE on that same edge.
  - After edge k+DEPTH, values = 0, rd_valid = 0 and rd_last = 0, unless a new read was accepted at k+DEPTH. In that case row 0 streams with no gap.
- UPD, with start_upd accepted at edge k:
  - delta_valid on edge k itself is ignored.
  - On each later edge with delta_valid = 1: mem[ptr] <= mem[ptr] (+) delta, lane-wise, then ptr++.
  - delta_valid = 0 stalls with no write and no ptr change, for unlimited cycles.
  - On the edge that writes row DEPTH-1, the state goes to IDLE and done pulses on the next cycle.
  - A read started afterwards observes all updated rows.
- Lane arithmetic:
  - The sum is computed in DATA_W+1 bits.
  - SATURATE=0 keeps the low DATA_W bits (wraps).
  - SATURATE=1 clamps to the range [-2^(DATA_W-1), 2^(DATA_W-1)-1] when the carry-sign mismatches.
  - Lanes are independent: there is no carry between lanes.
- CLR: one row is zeroed per edge, rows 0..DEPTH-1 over DEPTH edges. The state goes to IDLE after row DEPTH-1, and done pulses on the next cycle.
- In UPD and CLR, values and rd_valid stay 0.
- Counter wrap: ptr never exceeds DEPTH-1; the final-row comparison is against DEPTH-1. DEPTH need not be a power of 2.

Test Plan (bench parameters: DATA_W=8, LANES=4, DEPTH=5, except scenario 5):
1. Clear, then start_rd. Expect: done one cycle after the 5th clear write. The read gives values=0 for 5 cycles with rd_valid=1, rd_last only on the 5th, then rd_valid=0.
2. Clear, then update with delta lanes = row index + 1 (row 2 = 32'h03030303). Stall 3 cycles between rows 1 and 2, then read. Expect: row r = {4{r+1}}, done after row 4, busy low afterwards.
3. SATURATE=0: preload lanes to 8'h7F, apply delta 8'h01. Expect 8'h80. Repeat with SATURATE=1: expect 8'h7F; and 8'h80 plus delta 8'hFF gives 8'h80.
4. Raise start_rd, start_upd and start_clr on the same edge. Expect: READ entered, start_err pulses once, memory unchanged. Raise start_upd mid-read: expect start_err, read stream uninterrupted.
5. DEPTH=784, LANES=128, DATA_W=32, two back-to-back reads (start_rd re-asserted on the edge after rd_last). Expect 1568 contiguous rd_valid cycles and row order 0..783, 0..783.
6. Assert rst after 2 of 5 update rows, then read. Expect: rows 0–1 updated, rows 2–4 unchanged, no done pulse, all outputs 0 after reset.
